// File: rtl/cpu_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller_pkg
// Description : Shared definitions for the 8-bit CPU controller. Holds the
//               ALU opcodes, instruction class codes, MOVE op-field codes and
//               their ALU mapping, FSM state encoding and the decoded
//               instruction record.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_controller_pkg;

    // ALU opcodes driven on alu_op
    localparam logic [3:0] C_ALU_PUR = 4'h0;
    localparam logic [3:0] C_ALU_SHL = 4'h1;
    localparam logic [3:0] C_ALU_SHR = 4'h2;
    localparam logic [3:0] C_ALU_UNC = 4'h3;

    // Instruction class codes, IR[7:6]
    localparam logic [1:0] C_CLS_MOVE = 2'b00;
    localparam logic [1:0] C_CLS_JMP  = 2'b01;
    localparam logic [1:0] C_CLS_JOF  = 2'b10;
    localparam logic [1:0] C_CLS_HALT = 2'b11;

    // MOVE op field codes, IR[5:4]
    localparam logic [1:0] C_MOP_PUR = 2'b00;
    localparam logic [1:0] C_MOP_SHL = 2'b01;
    localparam logic [1:0] C_MOP_SHR = 2'b10;
    localparam logic [1:0] C_MOP_UNC = 2'b11;

    // Controller FSM states
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    // Decoded view of the instruction register
    typedef struct packed {
        logic [1:0] cls;
        logic [3:0] alu_op;
        logic [1:0] src;
        logic [1:0] dst;
        logic [5:0] target;
    } dec_t;

    // MOVE op field to ALU opcode
    function automatic logic [3:0] mop_to_alu(input logic [1:0] mop);
        logic [3:0] op;
        case (mop)
            C_MOP_SHL: op = C_ALU_SHL;
            C_MOP_SHR: op = C_ALU_SHR;
            C_MOP_UNC: op = C_ALU_UNC;
            default:   op = C_ALU_PUR;
        endcase
        return op;
    endfunction

endpackage : cpu_controller_pkg
`default_nettype wire

// File: rtl/cpu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_decoder
// Description : Purely combinational instruction decoder. Splits the
//               instruction register into class, ALU opcode, register
//               selects and jump target.
// Ports       : i_ir  [7:0] instruction register
//               o_dec dec_t decoded fields
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_decoder
    import cpu_controller_pkg::*;
(
    input  logic [7:0] i_ir,
    output dec_t       o_dec
);

    always_comb begin
        o_dec        = '0;
        o_dec.cls    = i_ir[7:6];
        o_dec.alu_op = mop_to_alu(i_ir[5:4]);
        o_dec.src    = i_ir[3:2];
        o_dec.dst    = i_ir[1:0];
        o_dec.target = i_ir[5:0];
    end

endmodule : cpu_decoder
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller
// Description : Fetch/decode/execute sequencer for the 8-bit CPU core. Fetches
//               instructions over a req/valid handshake, decodes them and
//               drives the ALU opcode, register-file selects and write enable.
//               Owns the program counter and the sticky overflow flag.
// Ports       : clk, reset           clock, synchronous active-high reset
//               instr_req/addr       fetch request and address (PC)
//               instr_valid/data     fetched instruction return
//               alu_op, src_sel      ALU opcode and operand read select
//               dst_sel, reg_we      register write select and enable pulse
//               shift_overflow       ALU overflow for the current alu_op
//               flag, halted         sticky overflow flag, HALT indication
//               resume               leave HALT and continue at PC
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_controller
    import cpu_controller_pkg::*;
#(
    parameter int                ADDR_W   = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              instr_req,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_valid,
    input  logic [7:0]        instr_data,
    output logic [3:0]        alu_op,
    output logic [1:0]        src_sel,
    output logic [1:0]        dst_sel,
    output logic              reg_we,
    input  logic              shift_overflow,
    output logic              flag,
    output logic              halted,
    input  logic              resume
);

    state_t            r_state_q, w_state_d;
    logic [ADDR_W-1:0] r_pc_q,    w_pc_d;
    logic [7:0]        r_ir_q,    w_ir_d;
    logic              r_flag_q,  w_flag_d;

    dec_t              w_dec;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_inc;

    cpu_decoder u_decoder (
        .i_ir  (r_ir_q),
        .o_dec (w_dec)
    );

    // Only the low ADDR_W bits of the 6-bit target field address the program
    assign w_target   = ADDR_W'(w_dec.target);
    assign w_pc_inc   = r_pc_q + ADDR_W'(1);
    assign instr_addr = r_pc_q;
    assign flag       = r_flag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_FETCH;
            r_pc_q    <= RESET_PC;
            r_ir_q    <= '0;
            r_flag_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_ir_q    <= w_ir_d;
            r_flag_q  <= w_flag_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_ir_d    = r_ir_q;
        w_flag_d  = r_flag_q;
        instr_req = 1'b0;
        alu_op    = C_ALU_PUR;
        src_sel   = 2'b00;
        dst_sel   = 2'b00;
        reg_we    = 1'b0;
        halted    = 1'b0;

        case (r_state_q)
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    w_ir_d    = instr_data;
                    w_state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case (w_dec.cls)
                    C_CLS_MOVE: begin
                        alu_op    = w_dec.alu_op;
                        src_sel   = w_dec.src;
                        w_state_d = S_EXEC;
                    end
                    C_CLS_JMP: begin
                        w_pc_d    = w_target;
                        w_state_d = S_FETCH;
                    end
                    C_CLS_JOF: begin
                        // Taken JOF consumes the flag
                        if (r_flag_q) begin
                            w_pc_d   = w_target;
                            w_flag_d = 1'b0;
                        end else begin
                            w_pc_d   = w_pc_inc;
                        end
                        w_state_d = S_FETCH;
                    end
                    default: begin
                        w_pc_d    = w_pc_inc;
                        w_state_d = S_HALT;
                    end
                endcase
            end

            S_EXEC: begin
                alu_op    = w_dec.alu_op;
                src_sel   = w_dec.src;
                dst_sel   = w_dec.dst;
                // A reset cycle must never commit a register write
                reg_we    = ~reset;
                w_flag_d  = r_flag_q | shift_overflow;
                w_pc_d    = w_pc_inc;
                w_state_d = S_FETCH;
            end

            default: begin
                halted = 1'b1;
                if (resume) begin
                    w_state_d = S_FETCH;
                end
            end
        endcase
    end

endmodule : cpu_controller
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_controller
// Description : Self-checking bench for cpu_controller. Directed instruction
//               table with hand-derived PC/flag results, multi-cycle corner
//               sequences (halt/resume, reset in EXEC) and random instruction
//               streams checked against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;
    import cpu_controller_pkg::*;

    localparam int C_AW    = 6;
    localparam int C_PSIZE = 1 << C_AW;

    logic            clk;
    logic            reset;
    logic            instr_req;
    logic [C_AW-1:0] instr_addr;
    logic            instr_valid;
    logic [7:0]      instr_data;
    logic [3:0]      alu_op;
    logic [1:0]      src_sel;
    logic [1:0]      dst_sel;
    logic            reg_we;
    logic            shift_overflow;
    logic            flag;
    logic            halted;
    logic            resume;

    cpu_controller #(
        .ADDR_W   (C_AW),
        .RESET_PC (6'd0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_req      (instr_req),
        .instr_addr     (instr_addr),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .alu_op         (alu_op),
        .src_sel        (src_sel),
        .dst_sel        (dst_sel),
        .reg_we         (reg_we),
        .shift_overflow (shift_overflow),
        .flag           (flag),
        .halted         (halted),
        .resume         (resume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Instruction-level model: architectural PC and flag only
    int m_pc   = 0;
    bit m_flag = 1'b0;

    typedef struct {
        logic [7:0] ins;
        bit         ovf;
        int         wt;
        int         exp_pc;
        bit         exp_flag;
        int         hold;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_alu"}, int'(alu_op), int'(C_ALU_PUR));
        chk({name, "_src"}, int'(src_sel), 0);
        chk({name, "_dst"}, int'(dst_sel), 0);
        chk({name, "_we"},  int'(reg_we), 0);
    endtask

    function automatic logic [3:0] exp_alu(input logic [1:0] op);
        case (op)
            2'd1:    return C_ALU_SHL;
            2'd2:    return C_ALU_SHR;
            2'd3:    return C_ALU_UNC;
            default: return C_ALU_PUR;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after a rising edge with the DUT in FETCH; leaves it the
    // same way, in FETCH or HALT.
    task automatic do_instr(input logic [7:0] ins, input bit ovf, input int wt);
        bit         is_move = (ins[7:6] == 2'b00);
        logic [1:0] op      = ins[5:4];
        bit         ovf_eff = ovf && (op == 2'd1 || op == 2'd2);
        bit         to_halt = (ins[7:6] == 2'b11);
        int         tgt     = int'(ins[5:0]) % C_PSIZE;

        for (int i = 0; i < wt; i++) begin
            instr_valid = 1'b0; instr_data = 8'($urandom);
            resume = 1'($urandom); shift_overflow = 1'($urandom);
            @(negedge clk);
            chk("wait_req", int'(instr_req), 1);
            chk("wait_addr", int'(instr_addr), m_pc);
            chk_idle("wait");
            tick();
        end

        instr_valid = 1'b1; instr_data = ins;
        resume = 1'($urandom); shift_overflow = 1'($urandom);
        @(negedge clk);
        chk("fetch_req", int'(instr_req), 1);
        chk("fetch_addr", int'(instr_addr), m_pc);
        chk_idle("fetch");
        tick();

        // DECODE: stray valid and overflow must be ignored here
        instr_valid = 1'($urandom); instr_data = 8'($urandom);
        shift_overflow = 1'($urandom);
        @(negedge clk);
        chk("dec_req", int'(instr_req), 0);
        if (is_move) begin
            chk("dec_alu", int'(alu_op), int'(exp_alu(op)));
            chk("dec_src", int'(src_sel), int'(ins[3:2]));
            chk("dec_dst", int'(dst_sel), 0);
            chk("dec_we",  int'(reg_we), 0);
        end else begin
            chk_idle("dec");
        end
        tick();

        if (is_move) begin
            shift_overflow = ovf_eff;
            @(negedge clk);
            chk("exec_alu", int'(alu_op), int'(exp_alu(op)));
            chk("exec_src", int'(src_sel), int'(ins[3:2]));
            chk("exec_dst", int'(dst_sel), int'(ins[1:0]));
            chk("exec_we",  int'(reg_we), 1);
            tick();
            m_flag = m_flag | ovf_eff;
            m_pc   = (m_pc + 1) % C_PSIZE;
        end else begin
            case (ins[7:6])
                2'b01: m_pc = tgt;
                2'b10: begin
                    if (m_flag) begin
                        m_pc   = tgt;
                        m_flag = 1'b0;
                    end else begin
                        m_pc = (m_pc + 1) % C_PSIZE;
                    end
                end
                default: m_pc = (m_pc + 1) % C_PSIZE;
            endcase
        end

        instr_valid = 1'b0; resume = 1'b0; shift_overflow = 1'($urandom);
        @(negedge clk);
        chk_idle("post");
        chk("post_flag", int'(flag), int'(m_flag));
        if (to_halt) begin
            chk("post_halted", int'(halted), 1);
            chk("post_req", int'(instr_req), 0);
        end else begin
            chk("post_halted", int'(halted), 0);
            chk("post_req", int'(instr_req), 1);
            chk("post_addr", int'(instr_addr), m_pc);
        end
        tick();
    endtask

    // Entered in HALT just after a rising edge; holds for n cycles with noise
    // on instr_valid, then pulses resume and checks the return to FETCH.
    task automatic do_resume(input int n);
        for (int i = 0; i < n; i++) begin
            instr_valid = 1'($urandom); instr_data = 8'($urandom);
            resume = 1'b0; shift_overflow = 1'($urandom);
            @(negedge clk);
            chk("halt_halted", int'(halted), 1);
            chk("halt_req", int'(instr_req), 0);
            chk_idle("halt");
            tick();
        end
        instr_valid = 1'b0; resume = 1'b1;
        @(negedge clk);
        chk("resume_halted", int'(halted), 1);
        tick();
        resume = 1'b0;
        @(negedge clk);
        chk("resumed_halted", int'(halted), 0);
        chk("resumed_req", int'(instr_req), 1);
        chk("resumed_addr", int'(instr_addr), m_pc);
        chk("resumed_flag", int'(flag), int'(m_flag));
        tick();
    endtask

    initial begin
        vec_t tbl[$];
        tbl.push_back('{8'h16, 1'b0, 1, 1,  1'b0, 0});   // MOVE SHL r1->r2
        tbl.push_back('{8'h20, 1'b1, 0, 2,  1'b1, 0});   // MOVE SHR, overflow
        tbl.push_back('{8'h8A, 1'b0, 0, 10, 1'b0, 0});   // JOF taken
        tbl.push_back('{8'h8A, 1'b0, 0, 11, 1'b0, 0});   // JOF not taken
        tbl.push_back('{8'h45, 1'b0, 2, 5,  1'b0, 0});   // JMP 5
        tbl.push_back('{8'h7F, 1'b0, 0, 63, 1'b0, 0});   // JMP 63
        tbl.push_back('{8'h31, 1'b1, 0, 0,  1'b0, 0});   // MOVE UNC, PC wraps
        tbl.push_back('{8'h05, 1'b0, 7, 1,  1'b0, 0});   // MOVE PUR, long wait
        tbl.push_back('{8'hC0, 1'b0, 0, 2,  1'b0, 20});  // HALT for 20 cycles

        reset = 1'b1; instr_valid = 1'b0; instr_data = 8'h00;
        shift_overflow = 1'b0; resume = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_we", int'(reg_we), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req", int'(instr_req), 1);
        chk("rst_addr", int'(instr_addr), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_flag", int'(flag), 0);
        chk_idle("rst");
        tick();

        foreach (tbl[i]) begin
            do_instr(tbl[i].ins, tbl[i].ovf, tbl[i].wt);
            @(negedge clk);
            chk($sformatf("tbl%0d_pc", i), int'(instr_addr), tbl[i].exp_pc);
            chk($sformatf("tbl%0d_flag", i), int'(flag), int'(tbl[i].exp_flag));
            tick();
            if (tbl[i].hold > 0) begin
                do_resume(tbl[i].hold);
            end
        end

        // Reset arriving in EXEC of a MOVE: no write, back to reset state
        do_instr(8'h16, 1'b1, 0);
        instr_valid = 1'b1; instr_data = 8'h16;
        tick();
        instr_valid = 1'b0;
        tick();
        reset = 1'b1; shift_overflow = 1'b1;
        @(negedge clk);
        chk("rexec_we", int'(reg_we), 0);
        tick();
        reset = 1'b0; shift_overflow = 1'b0;
        m_pc = 0; m_flag = 1'b0;
        @(negedge clk);
        chk("rexec_req", int'(instr_req), 1);
        chk("rexec_addr", int'(instr_addr), 0);
        chk("rexec_flag", int'(flag), 0);
        chk("rexec_halted", int'(halted), 0);
        chk_idle("rexec");
        tick();

        // Random instruction stream against the model
        for (int k = 0; k < 150; k++) begin
            logic [7:0] ins;
            ins = 8'($urandom_range(0, 255));
            do_instr(ins, 1'($urandom), int'($urandom_range(0, 3)));
            if (ins[7:6] == 2'b11) begin
                do_resume(int'($urandom_range(0, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_cpu_controller
`default_nettype wire

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Fetch/decode/execute sequencer for the 8-bit CPU core.
- Requests instructions from program memory with a req/valid handshake, decodes them and drives the ALU opcode, register-file selects and write enable.
- Keeps the program counter and a sticky overflow flag captured from the ALU shift overflow.
- Sits between program memory and the ALU/register-file datapath.

Parameters:
- ADDR_W, 6, program counter and instruction address width (64-word program space).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_req  output  1  instruction fetch request.
- instr_addr  output  ADDR_W  fetch address (current PC).
- instr_valid  input  1  instr_data valid; accepted only while instr_req=1.
- instr_data  input  8  instruction word.
- alu_op  output  4  ALU opcode (`PUROP/`SHLOP/`SHROP/`UNCOP`).
- src_sel  output  2  register-file read select driven into the ALU operand.
- dst_sel  output  2  register-file write select.
- reg_we  output  1  register-file write enable, one-cycle pulse.
- shift_overflow  input  1  ALU overflow for the current alu_op.
- flag  output  1  sticky overflow flag.
- halted  output  1  high while in HALT.
- resume  input  1  leave HALT and continue at PC.

Behaviour:
- Instruction format: [7:6] class; 00 MOVE, 01 JMP, 10 JOF, 11 HALT.
- MOVE fields: [5:4] op (00 PUR, 01 SHL, 10 SHR, 11 UNC); [3:2] src; [1:0] dst.
- JMP/JOF: [5:0] absolute target; only the low ADDR_W bits are used.
- States: FETCH, DECODE, EXEC, HALT.
- FETCH: instr_req=1, instr_addr=PC. Waits indefinitely for instr_valid. On the valid cycle the instruction is latched into IR and the FSM moves to DECODE.
- DECODE, MOVE: drive alu_op and src_sel from IR, then go to EXEC.
- DECODE, JMP: PC<=target, go to FETCH.
- DECODE, JOF with flag=1: PC<=target, flag<=0, go to FETCH.
- DECODE, JOF with flag=0: PC<=PC+1, go to FETCH.
- DECODE, HALT: PC<=PC+1, go to HALT.
- EXEC: alu_op/src_sel/dst_sel held from IR; reg_we=1 for exactly this cycle; flag<=flag|shift_overflow; PC<=PC+1; go to FETCH.
- Latency: a MOVE takes 3 cycles from the instr_valid cycle (FETCH accept, DECODE, EXEC). JMP and JOF take 2.
- Idle encoding: outside DECODE/EXEC, alu_op=`PUROP`, src_sel=dst_sel=0, reg_we=0.
- HALT: halted=1, instr_req=0. resume=1 moves to FETCH next cycle. resume in any other state is ignored.
- PC increments and wraps modulo 2^ADDR_W; PC=2^ADDR_W-1 followed by +1 gives 0.
- Flag: sticky. Cleared only by reset or by a taken JOF. UNC and PUR contribute 0, since the ALU drives overflow 0 for them.
- instr_valid while instr_req=0 is ignored.
- Reset, synchronous and taking priority over everything (including mid-fetch or mid-EXEC): state=FETCH, PC=RESET_PC, IR=0, flag=0, reg_we=0, halted=0, alu_op=`PUROP`, selects=0. instr_req is 1 in the first cycle after reset deasserts.
- No write ever occurs in a cycle with reset=1.

Decomposition:
- cpu_definitions.vh (shared):
  - ALU opcodes `PUROP/`SHLOP/`SHROP/`UNCOP`, `TRUE`.
  - Class codes `CLS_MOVE/`CLS_JMP/`CLS_JOF/`CLS_HALT`.
  - 2-bit MOVE op field codes and the field-to-alu_op mapping constants.
  - FSM state encodings.
- Sub-module: cpu_decoder, purely combinational, IR -> {class, alu_op, src, dst, target}. The FSM, PC and flag stay in cpu_controller.

Test Plan:
- Reset, then MOVE SHL r1->r2 (0x16) returned with instr_valid one cycle later -> alu_op=`SHLOP`, src_sel=1, dst_sel=2. reg_we pulses exactly one cycle, 3 cycles after valid accept. PC 0->1.
- MOVE SHR (0x20) with shift_overflow=1 in EXEC -> flag=1. Following JOF 0x8A (target 10) -> PC=10 and flag=0. A second JOF 0x8A -> not taken, PC=11.
- JMP 0x7F at PC=5 -> PC=63. MOVE at PC=63 -> PC wraps to 0.
- HALT (0xC0) -> halted=1, instr_req=0 for 20 cycles, no reg_we. resume pulse -> FETCH next cycle with instr_addr=PC+1.
- instr_valid held low 7 cycles during FETCH -> instr_req stays 1 and outputs stay idle. Spurious instr_valid while halted -> ignored.
- reset asserted during EXEC of a MOVE -> reg_we=0 that cycle. Next cycle PC=RESET_PC, flag=0, state FETCH.
